rbm_neuron_ctrl: RTL

RBM_NEURON_CTRL -- requirements
Module: rbm_neuron_ctrl

---
 rtl/rbm_pkg.sv | 36 +++
 rtl/rbm_neuron_ctrl_sigmoid.sv | 26 ++
 rtl/rbm_neuron_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rbm_pkg.sv
// Shared FSM encoding and Q-format constants for the RBM neuron controller.
// Sum is Q8.4 two's complement; sigmoid output is Q0.8 with 0x80 = 1.0.
package rbm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StSigm,
    StSample,
    StDone
  } state_e;

  localparam int unsigned FracBits = 4;
  localparam int unsigned SigOne   = 'h80;

  // PLAN breakpoints on |x| in raw sum units: 1.0, 2.375, 5.0
  localparam int unsigned Bp1 = 1 << FracBits;
  localparam int unsigned Bp2 = (19 << FracBits) >> 3;
  localparam int unsigned Bp3 = 5 << FracBits;

  // Piecewise-linear sigmoid of a non-negative magnitude, in SigOne units.
  function automatic int unsigned plan_mag(input int unsigned a);
    int unsigned y;
    if (a >= Bp3) begin
      y = SigOne;
    end else if (a >= Bp2) begin
      y = ((SigOne * 27) >> 5) + ((a * (SigOne >> 5)) >> FracBits);
    end else if (a >= Bp1) begin
      y = ((SigOne * 5) >> 3) + ((a * (SigOne >> 3)) >> FracBits);
    end else begin
      y = (SigOne >> 1) + ((a * (SigOne >> 2)) >> FracBits);
    end
    return y;
  endfunction

endpackage

// File: rtl/rbm_neuron_ctrl_sigmoid.sv
// Combinational PLAN sigmoid: Q8.4 signed sum in, Q0.8 probability out (0x80 = 1.0).
// Negative inputs use the symmetry sigma(-x) = 1 - sigma(x).
module rbm_neuron_ctrl_sigmoid
  import rbm_pkg::*;
#(
  parameter int unsigned input_bitlength = 12,
  parameter int unsigned bitlength       = 8
) (
  input  logic [input_bitlength-1:0] sum_i,
  output logic [bitlength-1:0]       sig_o
);

  logic signed [input_bitlength:0] sum_ext;
  logic        [input_bitlength:0] mag;
  logic        [31:0]              y_pos;
  logic        [31:0]              y_neg;

  // One extra bit so the most negative sum has a representable magnitude
  assign sum_ext = {sum_i[input_bitlength-1], sum_i};
  assign mag     = sum_ext[input_bitlength] ? -sum_ext : sum_ext;
  assign y_pos   = plan_mag(32'(mag));
  assign y_neg   = SigOne - y_pos;

  assign sig_o = sum_i[input_bitlength-1] ? bitlength'(y_neg) : bitlength'(y_pos);

endmodule

// File: rtl/rbm_neuron_ctrl.sv
// RBM neuron controller: accumulates product terms, applies sigmoid, samples spikes.
// Optional SAT_ACCUM_EN makes the accumulator saturate instead of wrapping.
module rbm_neuron_ctrl
  import rbm_pkg::*;
#(
  parameter int unsigned input_bitlength = 12,
  parameter int unsigned bitlength       = 8,
  parameter int unsigned NUM_VISIBLE     = 784,
  parameter int unsigned NUM_ITER        = 100
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              prod_valid,
  input  logic [input_bitlength-1:0]        prod_data,
  output logic                              prod_ready,
  input  logic [bitlength-1:0]              rand_num,
  output logic                              rand_req,
  output logic                              busy,
  output logic                              spike,
  output logic [$clog2(NUM_ITER+1)-1:0]     spike_count,
  output logic                              done
);

  localparam int unsigned TermW = $clog2(NUM_VISIBLE + 1);
  localparam int unsigned IterW = $clog2(NUM_ITER + 1);
  localparam int unsigned CntW  = $clog2(NUM_ITER + 1);
  localparam int unsigned Msb   = input_bitlength - 1;

  localparam logic [TermW-1:0] LastTerm = TermW'(NUM_VISIBLE - 1);
  localparam logic [IterW-1:0] LastIter = IterW'(NUM_ITER - 1);

  state_e                     state_q, state_d;
  logic [input_bitlength-1:0] sum_q, sum_d;
  logic [TermW-1:0]           term_cnt_q, term_cnt_d;
  logic [IterW-1:0]           iter_cnt_q, iter_cnt_d;
  logic [bitlength-1:0]       s_reg_q, s_reg_d;
  logic                       spike_q, spike_d;
  logic [CntW-1:0]            count_q, count_d;

  logic [input_bitlength-1:0] acc_raw;
  logic [input_bitlength-1:0] acc_next;
  logic [bitlength-1:0]       sig_out;
  logic                       sample_hit;

  assign acc_raw = sum_q + prod_data;

`ifdef SAT_ACCUM_EN
  logic pos_ovf;
  logic neg_ovf;

  // Overflow only when both operands share a sign the result does not
  assign pos_ovf = !sum_q[Msb] && !prod_data[Msb] && acc_raw[Msb];
  assign neg_ovf = sum_q[Msb] && prod_data[Msb] && !acc_raw[Msb];

  always_comb begin
    acc_next = acc_raw;
    if (pos_ovf) begin
      acc_next = {1'b0, {Msb{1'b1}}};
    end else if (neg_ovf) begin
      acc_next = {1'b1, {Msb{1'b0}}};
    end
  end
`else
  assign acc_next = acc_raw;
`endif

  rbm_neuron_ctrl_sigmoid #(
    .input_bitlength(input_bitlength),
    .bitlength      (bitlength)
  ) sigmoid (
    .sum_i(sum_q),
    .sig_o(sig_out)
  );

  // MSB of the random sample is dropped so 0x80 always wins and 0x00 never does
  assign sample_hit = {1'b0, rand_num[bitlength-2:0]} < s_reg_q;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    term_cnt_d = term_cnt_q;
    iter_cnt_d = iter_cnt_q;
    s_reg_d    = s_reg_q;
    spike_d    = spike_q;
    count_d    = count_q;
    prod_ready = 1'b0;
    rand_req   = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAccum;
          sum_d      = '0;
          term_cnt_d = '0;
          iter_cnt_d = '0;
          count_d    = '0;
          spike_d    = 1'b0;
        end
      end
      StAccum: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          sum_d      = acc_next;
          term_cnt_d = term_cnt_q + TermW'(1);
          if (term_cnt_q == LastTerm) begin
            state_d = StSigm;
          end
        end
      end
      StSigm: begin
        s_reg_d = sig_out;
        state_d = StSample;
      end
      StSample: begin
        rand_req = 1'b1;
        spike_d  = sample_hit;
        if (sample_hit) begin
          count_d = count_q + CntW'(1);
        end
        if (iter_cnt_q == LastIter) begin
          state_d = StDone;
        end else begin
          iter_cnt_d = iter_cnt_q + IterW'(1);
          sum_d      = '0;
          term_cnt_d = '0;
          state_d    = StAccum;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      term_cnt_q <= '0;
      iter_cnt_q <= '0;
      s_reg_q    <= '0;
      spike_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      term_cnt_q <= term_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      s_reg_q    <= s_reg_d;
      spike_q    <= spike_d;
      count_q    <= count_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign spike       = spike_q;
  assign spike_count = count_q;

endmodule
